// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types for the RAM responder slice
package mem_pkg;

  typedef logic [31:0] word_t;
  typedef logic [3:0]  strb_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } resp_state_t;

  // Index width that still works for a single-word array.
  function automatic int unsigned idx_width(int unsigned depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/ram_array.sv
// rtl/ram_array.sv - word array with byte-lane write enables and a registered read port
module ram_array
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH = 1536,
  parameter int unsigned AW    = 11
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          en_i,
  input  logic          hit_i,
  input  logic [AW-1:0] idx_i,
  input  strb_t         we_i,
  input  word_t         wdata_i,
  output word_t         rdata_o
);

  word_t mem_q [DEPTH];
  word_t rdata_q;

  // Contents are deliberately left out of reset so data survives a bus reset.
  always_ff @(posedge clk) begin
    if (en_i && hit_i) begin
      for (int i = 0; i < 4; i++) begin
        if (we_i[i]) begin
          mem_q[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
  end

  // Old word is sampled on the same edge as the write, giving read-before-write.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata_q <= '0;
    end else if (en_i) begin
      rdata_q <= hit_i ? mem_q[idx_i] : '0;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_responder.sv
// rtl/ram_responder.sv - wait-stated memory responder; RAM_RESPONDER_ERR_EN enables the err flag
module ram_responder
  import mem_pkg::*;
#(
  parameter logic [31:0] BASE        = 32'h0000_0400,
  parameter int unsigned SIZE_WORDS  = 1536,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        err
);

  localparam int unsigned AW       = idx_width(SIZE_WORDS);
  localparam logic [32:0] LIMIT    = {1'b0, BASE} + (33'(SIZE_WORDS) << 2);
  localparam logic [3:0]  CNT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  resp_state_t   state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          hit_q, hit_d;
  word_t         wdata_q, wdata_d;
  strb_t         wstrb_q, wstrb_d;
  logic          ram_en;

  // 33-bit compare so a window ending at the top of the address space cannot wrap.
  logic [32:0]   addr_ext;
  logic [32:0]   offset;
  logic          live_hit;
  logic [AW-1:0] live_idx;

  assign addr_ext = {1'b0, mem_addr};
  assign offset   = addr_ext - {1'b0, BASE};
  assign live_hit = (addr_ext >= {1'b0, BASE}) && (addr_ext < LIMIT);
  assign live_idx = offset[AW+1:2];

  logic unused_bits;
  assign unused_bits = ^{offset[32:AW+2], offset[1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    hit_d   = hit_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    ram_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_valid) begin
          idx_d   = live_idx;
          hit_d   = live_hit;
          wdata_d = mem_wdata;
          wstrb_d = mem_wstrb;
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
            ram_en  = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (!mem_valid) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd0) begin
          state_d = RESP;
          ram_en  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      hit_q   <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      hit_q   <= hit_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
    end
  end

  // Next-state capture values feed the array so a zero-wait access uses the live request.
  ram_array #(
    .DEPTH (SIZE_WORDS),
    .AW    (AW)
  ) u_ram_array (
    .clk     (clk),
    .resetn  (resetn),
    .en_i    (ram_en),
    .hit_i   (hit_d),
    .idx_i   (idx_d),
    .we_i    (wstrb_d),
    .wdata_i (wdata_d),
    .rdata_o (mem_rdata)
  );

  assign mem_ready = (state_q == RESP);

`ifdef RAM_RESPONDER_ERR_EN
  assign err = (state_q == RESP) && !hit_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ram_responder.sv
// tb/tb_ram_responder.sv - directed and randomized checks of ram_responder against a word-array model
module tb_ram_responder;

  localparam logic [31:0] BASE = 32'h0000_0400;
  localparam int SZ = 1536;

  logic        clk = 1'b0;
  logic        resetn;
  logic        v2, v0;
  logic [31:0] addr, wdata;
  logic [3:0]  wstrb;
  logic        rdy2, rdy0, err2, err0;
  logic [31:0] rd2, rd0;

  always #5 clk = ~clk;

  ram_responder #(.BASE(BASE), .SIZE_WORDS(SZ), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .resetn(resetn), .mem_valid(v2), .mem_addr(addr), .mem_wdata(wdata),
    .mem_wstrb(wstrb), .mem_ready(rdy2), .mem_rdata(rd2), .err(err2)
  );

  ram_responder #(.BASE(BASE), .SIZE_WORDS(SZ), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .resetn(resetn), .mem_valid(v0), .mem_addr(addr), .mem_wdata(wdata),
    .mem_wstrb(wstrb), .mem_ready(rdy0), .mem_rdata(rd0), .err(err0)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int sel = 0;
  logic [31:0] mdl [2][SZ];
  bit          known [2][SZ];

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit in_range(logic [31:0] a);
    longint x = longint'(a);
    return (x >= longint'(BASE)) && (x < longint'(BASE) + 4 * SZ);
  endfunction

  function automatic int word_idx(logic [31:0] a);
    return int'((longint'(a) - longint'(BASE)) / 4);
  endfunction

  function automatic logic exp_err(bit hit);
`ifdef RAM_RESPONDER_ERR_EN
    return !hit;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic cur_ready();
    return (sel != 0) ? rdy0 : rdy2;
  endfunction

  function automatic logic cur_err();
    return (sel != 0) ? err0 : err2;
  endfunction

  function automatic logic [31:0] cur_rdata();
    return (sel != 0) ? rd0 : rd2;
  endfunction

  task automatic set_valid(logic v);
    if (sel != 0) v0 = v;
    else v2 = v;
  endtask

  // One full transaction; inputs are scrambled after the sampling edge to prove capture.
  task automatic access(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input string tag, output logic [31:0] rd);
    int n;
    int wc;
    bit hit;
    int ix;
    wc  = (sel != 0) ? 0 : 2;
    hit = in_range(a);
    ix  = hit ? word_idx(a) : 0;
    addr = a; wdata = d; wstrb = s;
    set_valid(1'b1);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        addr = $urandom; wdata = $urandom; wstrb = 4'($urandom);
      end
    end while (!cur_ready() && n < 20);
    set_valid(1'b0);
    rd = cur_rdata();
    check({tag, " latency"}, 32'(n), 32'(wc + 1));
    if (!hit) check({tag, " rdata"}, rd, 32'h0);
    else if (known[sel][ix]) check({tag, " rdata"}, rd, mdl[sel][ix]);
    check({tag, " err"}, 32'(cur_err()), 32'(exp_err(hit)));
    if (hit) begin
      for (int i = 0; i < 4; i++)
        if (s[i]) mdl[sel][ix][8*i +: 8] = d[8*i +: 8];
      if (s == 4'hF) known[sel][ix] = 1'b1;
    end
    @(posedge clk); #1;
    check({tag, " pulse"}, 32'(cur_ready()), 32'h0);
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] a;
    logic [3:0]  s;
    int p;

    resetn = 1'b0; v2 = 1'b0; v0 = 1'b0;
    addr = '0; wdata = '0; wstrb = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset ready2", 32'(rdy2), 32'h0);
    check("reset err2", 32'(err2), 32'h0);
    check("reset rdata2", rd2, 32'h0);
    check("reset ready0", 32'(rdy0), 32'h0);
    check("reset err0", 32'(err0), 32'h0);
    check("reset rdata0", rd0, 32'h0);
    resetn = 1'b1;

    sel = 0;
    access(32'h400, 32'hDEADBEEF, 4'hF, "wr400", rd);
    access(32'h400, 32'h0, 4'h0, "rd400", rd);
    check("rd400 const", rd, 32'hDEADBEEF);

    access(32'h404, 32'h11223344, 4'hF, "wr404", rd);
    access(32'h404, 32'h000000AA, 4'b0001, "wr404b0", rd);
    check("rbw404 const", rd, 32'h11223344);
    access(32'h404, 32'h0, 4'h0, "rd404", rd);
    check("rd404 const", rd, 32'h112233AA);

    access(32'h2000, 32'h0, 4'h0, "rd2000", rd);
    access(32'h2400, 32'hCAFEF00D, 4'hF, "wr2400 alias", rd);
    access(32'h400, 32'h0, 4'h0, "rd400 after oor", rd);
    check("rd400 unchanged", rd, 32'hDEADBEEF);

    access(32'h408, 32'h55667788, 4'hF, "wr408", rd);
    addr = 32'h408; wdata = 32'h99999999; wstrb = 4'hF;
    v2 = 1'b1;
    @(posedge clk); #1;
    v2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("abort no ready", 32'(rdy2), 32'h0);
    end
    access(32'h408, 32'h0, 4'h0, "rd408 after abort", rd);
    check("rd408 const", rd, 32'h55667788);

    for (int i = 0; i < 10; i++) begin
      a = (i < 8) ? BASE + 32'(4 * i) : BASE + 32'(4 * (SZ - 10 + i));
      access(a, $urandom, 4'hF, "init", rd);
    end

    for (int k = 0; k < 40; k++) begin
      p = $urandom_range(0, 13);
      case (p)
        8:  a = BASE + 32'(4 * (SZ - 2));
        9:  a = BASE + 32'(4 * (SZ - 1));
        10: a = BASE - 32'd4;
        11: a = BASE + 32'(4 * SZ);
        12: a = 32'h2400;
        13: a = 32'hFFFF_FFFC;
        default: a = BASE + 32'(4 * p);
      endcase
      if (p < 10) a = a | 32'($urandom_range(0, 3));
      s = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
      access(a, $urandom, s, "rand", rd);
    end

    access(32'h408, 32'h0, 4'h0, "rd408 pre-reset", rd);
    addr = 32'h40C; wdata = 32'h12345678; wstrb = 4'hF;
    v2 = 1'b1;
    @(posedge clk); #1;
    resetn = 1'b0;
    #1;
    check("rst ready", 32'(rdy2), 32'h0);
    check("rst err", 32'(err2), 32'h0);
    check("rst rdata", rd2, 32'h0);
    check("rst state", 32'(dut2.state_q), 32'(mem_pkg::IDLE));
    v2 = 1'b0;
    #1;
    resetn = 1'b1;
    access(32'h400, 32'h0, 4'h0, "rd400 after reset", rd);
    access(32'h40C, 32'h0, 4'h0, "rd40C after reset", rd);

    sel = 1;
    access(32'h400, 32'hA5A5_5A5A, 4'hF, "w0 wr400", rd);
    access(32'h400, 32'h0000_FF00, 4'b0010, "w0 wr400b1", rd);
    access(32'h400, 32'h0, 4'h0, "w0 rd400", rd);
    check("w0 rd400 const", rd, 32'hA5A5_FF5A);
    access(32'hFFFF_FFFC, 32'h0, 4'h0, "w0 oor", rd);

    addr = 32'h400; wstrb = 4'h0;
    v0 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("b2b ready", 32'(rdy0), 32'((i % 2) == 0));
    end
    check("b2b rdata", rd0, 32'hA5A5_FF5A);
    v0 = 1'b0;
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_responder.md
RAM_RESPONDER -- requirements
Module: ram_responder

Interface
REQ-001 SHALL have parameter BASE, default 32'h0000_0400, byte address of first word.
REQ-002 SHALL have parameter SIZE_WORDS, default 1536, number of 32-bit words (power of two not required).
REQ-003 SHALL have parameter WAIT_CYCLES, default 2, extra wait states per access (0..15).
REQ-004 SHALL have port clk  in  1  sole clock; all state on rising edge.
REQ-005 SHALL have port resetn  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port mem_valid  in  1  initiator request; held until mem_ready seen.
REQ-007 SHALL have port mem_addr  in  32  byte address; bits [1:0] ignored.
REQ-008 SHALL have port mem_wdata  in  32  write data.
REQ-009 SHALL have port mem_wstrb  in  4  byte write strobes; 4'b0000 = read.
REQ-010 SHALL have port mem_ready  out  1  one-cycle completion pulse.
REQ-011 SHALL have port mem_rdata  out  32  read data, valid while mem_ready=1.
REQ-012 SHALL have port err  out  1  out-of-range flag, coincident with mem_ready.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-014 IDLE: mem_valid=1 SHALL load wait counter with WAIT_CYCLES-1 and go to WAIT; if WAIT_CYCLES=0, SHALL go directly to RESP.
REQ-015 WAIT: counter SHALL decrement each cycle; at 0 SHALL go to RESP.
REQ-016 WAIT: mem_valid=0 SHALL abort to IDLE with no array write and no mem_ready.
REQ-017 RESP: mem_ready SHALL be 1 for exactly one cycle, then FSM SHALL return to IDLE unconditionally (one idle cycle between transactions).
REQ-018 Latency: mem_ready SHALL assert WAIT_CYCLES+1 cycles after the edge that samples mem_valid=1 in IDLE.
REQ-019 Address, wdata, wstrb SHALL be captured on leaving IDLE; later input changes SHALL be ignored.
REQ-020 In range: BASE <= addr < BASE+4*SIZE_WORDS (33-bit compare, no wrap); index = (addr-BASE)>>2.
REQ-021 Write: on the edge entering RESP, each byte lane i with wstrb[i]=1 SHALL be written; others unchanged.
REQ-022 Read: mem_rdata SHALL be registered on the edge entering RESP from the captured index; SHALL read 0 when out of range.
REQ-023 Write cycles SHALL also return the pre-write word on mem_rdata (read-before-write).
REQ-024 Out of range: writes SHALL be dropped, access SHALL still complete with mem_ready (no bus hang).
REQ-025 mem_rdata SHALL hold its value outside RESP; only mem_ready qualifies it.

Reset
REQ-026 resetn=0 SHALL force IDLE, mem_ready=0, err=0, mem_rdata=0, counter=0 immediately, including mid-WAIT/RESP.
REQ-027 Array contents SHALL NOT be reset.
REQ-028 First request SHALL be accepted on the first rising edge after resetn deasserts.

Configuration
REQ-029 Macro RAM_RESPONDER_ERR_EN defined: err SHALL be 1 in the RESP cycle of an out-of-range access, else 0.
REQ-030 Macro undefined: err SHALL be tied 0 and range-check error logic omitted; out-of-range behaviour of REQ-024 unchanged.

Structure
REQ-031 Package mem_pkg SHALL hold word_t (32b), strb_t (4b), resp_state_t enum {IDLE, WAIT, RESP}.
REQ-032 Storage SHALL be sub-module ram_array (byte-lane write enables, synchronous read) instantiated once.
REQ-033 FSM, counter, capture and range check SHALL live in ram_responder.

Verification
REQ-034 WAIT_CYCLES=2: write 32'hDEADBEEF, wstrb=4'hF to 32'h400 -> mem_ready on 3rd edge after valid sample; read 32'h400 -> 32'hDEADBEEF.
REQ-035 Write 32'h000000AA wstrb=4'b0001 to 32'h404 after 32'h11223344 -> read 32'h112233AA.
REQ-036 Read 32'h2000 (out of range) -> mem_ready pulse, mem_rdata=0, err=1 with RAM_RESPONDER_ERR_EN, err=0 without; array unchanged.
REQ-037 Drop mem_valid one cycle into WAIT during write to 32'h408 -> no mem_ready; later read of 32'h408 returns old value.
REQ-038 Assert resetn=0 in WAIT -> mem_ready=0, state IDLE same cycle; prior array data retained after reset.
REQ-039 WAIT_CYCLES=0: back-to-back valid -> mem_ready every 2nd cycle, latency 1.
